// File: rtl/ps2_pkg.sv
// Shared types, prefix constants and helpers for the PS/2 keyboard decoder.
package ps2_pkg;

  // Receive frame states: start bit wait, 8 data bits, parity bit, stop bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Scancode prefixes.
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  // Device responses and overrun codes that never map to a key.
  localparam int NUM_DISCARD = 6;
  localparam logic [7:0] DISCARD_CODES [NUM_DISCARD] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
  };

  // Bytes still to drop after E1 so the 8-byte Pause sequence vanishes.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // PS/2 uses odd parity over data plus parity bit.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

  // True when the byte is a device response rather than a scancode.
  function automatic logic is_discard_code(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_DISCARD; i++) begin
      hit = hit | (code == DISCARD_CODES[i]);
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the raw PS/2 pins and the decoded key event word.
interface ps2_key_decoder_if;
  logic        ps2_clk_in;
  logic        ps2_dat_in;
  logic [10:0] ps2_key;
  logic        frame_err;

  // Decoder side: consumes the pins, produces the event word.
  modport master (
    input  ps2_clk_in,
    input  ps2_dat_in,
    output ps2_key,
    output frame_err
  );

  // Pin source / event consumer side.
  modport slave (
    output ps2_clk_in,
    output ps2_dat_in,
    input  ps2_key,
    input  frame_err
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes the PS/2 lines, deglitches the clock and flags its falling edges.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic fclk_fall,
  output logic dat_sync
);

  logic [1:0]            clk_sync_r;
  logic [1:0]            dat_sync_r;
  logic [FILTER_LEN-1:0] filt_r;
  logic [FILTER_LEN-1:0] filt_next_s;
  logic                  fclk_r;
  logic                  fclk_fall_r;

  // Next filter contents; deciding on it lets the edge pulse fire as the last sample lands.
  always_comb begin
    filt_next_s = {filt_r[FILTER_LEN-2:0], clk_sync_r[1]};
  end

  // Two-flop synchronizers, idle-high so reset does not look like a falling edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
      dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
    end
  end

  // Glitch filter with hysteresis: the level only changes on a full run of equal samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      filt_r      <= '1;
      fclk_r      <= 1'b1;
      fclk_fall_r <= 1'b0;
    end else begin
      filt_r      <= filt_next_s;
      fclk_fall_r <= 1'b0;
      if (filt_next_s == '0) begin
        fclk_r      <= 1'b0;
        fclk_fall_r <= fclk_r;
      end else if (&filt_next_s) begin
        fclk_r <= 1'b1;
      end else begin
        fclk_r <= fclk_r;
      end
    end
  end

  assign fclk_fall = fclk_fall_r;
  assign dat_sync  = dat_sync_r[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frame FSM, timeout and scancode prefix decoding
// into a toggle-strobed 11-bit key event word.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 96000
) (
  input  logic               clk_sys,
  input  logic               reset,
  ps2_key_decoder_if.master  key_if
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic             fclk_fall_s;
  logic             dat_s;

  ps2_state_e       state_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             par_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             byte_valid_r;
  logic             frame_err_r;

  logic [10:0]      key_r;
  logic             ext_r;
  logic             brk_r;
  logic [2:0]       skip_r;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk_in (key_if.ps2_clk_in),
    .ps2_dat_in (key_if.ps2_dat_in),
    .fclk_fall  (fclk_fall_s),
    .dat_sync   (dat_s)
  );

  // Frame receiver: bit-level FSM stepped by filtered clock falls, with a stall timeout.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      tmo_cnt_r    <= '0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (fclk_fall_s) begin
        tmo_cnt_r <= '0;
        case (state_r)
          IDLE: begin
            if (!dat_s) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= IDLE;
            end
          end
          DATA: begin
            shift_r   <= {dat_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end else begin
              state_r <= DATA;
            end
          end
          PARITY: begin
            par_r   <= dat_s;
            state_r <= STOP;
          end
          STOP: begin
            if (dat_s && frame_parity_ok(shift_r, par_r)) begin
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end else if (state_r == IDLE) begin
        tmo_cnt_r <= '0;
      end else if (tmo_cnt_r == TMO_W'(TIMEOUT)) begin
        // Keyboard went quiet mid-frame: drop what was collected.
        state_r     <= IDLE;
        frame_err_r <= 1'b1;
        tmo_cnt_r   <= '0;
        shift_r     <= 8'h00;
        bit_cnt_r   <= 3'd0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
    end
  end

  // Prefix decoder: folds E0/F0 into flags, swallows Pause and device responses, emits events.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_r  <= 11'h000;
      ext_r  <= 1'b0;
      brk_r  <= 1'b0;
      skip_r <= 3'd0;
    end else if (byte_valid_r) begin
      if (skip_r != 3'd0) begin
        skip_r <= skip_r - 3'd1;
      end else begin
        case (shift_r)
          CODE_EXT: begin
            ext_r <= 1'b1;
          end
          CODE_BRK: begin
            brk_r <= 1'b1;
          end
          CODE_PAUSE: begin
            skip_r <= PAUSE_SKIP;
            ext_r  <= 1'b0;
            brk_r  <= 1'b0;
          end
          default: begin
            if (!is_discard_code(shift_r)) begin
              key_r <= {~key_r[10], ~brk_r, ext_r, shift_r};
            end else begin
              key_r <= key_r;
            end
            ext_r <= 1'b0;
            brk_r <= 1'b0;
          end
        endcase
      end
    end else begin
      key_r <= key_r;
    end
  end

  assign key_if.ps2_key   = key_r;
  assign key_if.frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames on the pins and checks key events.
module tb_ps2_key_decoder;

  localparam int FLEN = 8;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_cycles = 0;
  int   err_rises  = 0;
  logic err_prev   = 1'b0;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .FILTER_LEN (FLEN),
    .TIMEOUT    (TO)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .key_if  (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Tally frame_err high cycles and distinct pulses.
  always @(negedge clk_sys) begin
    if (bus.frame_err) err_cycles++;
    if (bus.frame_err && !err_prev) err_rises++;
    err_prev = bus.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Send bits 0..n-1 of a frame; optionally glitch the clock low 4 cycles after bit gbit.
  task automatic send_bits(input logic [10:0] fr, input int n, input int gbit);
    for (int i = 0; i < n; i++) begin
      bus.ps2_dat_in = fr[i];
      wait_cyc(HALF);
      bus.ps2_clk_in = 1'b0;
      wait_cyc(HALF);
      bus.ps2_clk_in = 1'b1;
      if (i == gbit) begin
        wait_cyc(6);
        bus.ps2_clk_in = 1'b0;
        wait_cyc(4);
        bus.ps2_clk_in = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input int gbit);
    send_bits(mk_frame(b, bad_par), 11, gbit);
    bus.ps2_dat_in = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  int e0;

  initial begin
    bus.ps2_clk_in = 1'b1;
    bus.ps2_dat_in = 1'b1;
    wait_cyc(3);
    @(negedge clk_sys);
    check("rst_key", 32'(bus.ps2_key), 32'h000);
    check("rst_err", 32'(bus.frame_err), 32'h0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(20);

    // 1: frame 1D with latency check on the stop bit
    send_bits(mk_frame(8'h1D, 1'b0), 10, -1);
    bus.ps2_dat_in = 1'b1;
    wait_cyc(HALF);
    bus.ps2_clk_in = 1'b0;
    repeat (11) @(posedge clk_sys);
    @(negedge clk_sys);
    check("lat_before", 32'(bus.ps2_key), 32'h000);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("lat_1d", 32'(bus.ps2_key), 32'h61D);
    wait_cyc(HALF);
    bus.ps2_clk_in = 1'b1;
    wait_cyc(2 * HALF);
    check("err_none_1", 32'(err_rises), 32'd0);

    // 2: E0 F0 75 -> extended release
    send_byte(8'hE0, 1'b0, -1);
    check("hold_e0", 32'(bus.ps2_key), 32'h61D);
    send_byte(8'hF0, 1'b0, -1);
    check("hold_f0", 32'(bus.ps2_key), 32'h61D);
    send_byte(8'h75, 1'b0, -1);
    check("key_e075", 32'(bus.ps2_key), 32'h175);

    // 3: bad parity, then valid 1C with a glitch inside the frame
    e0 = err_rises;
    send_byte(8'h1C, 1'b1, -1);
    check("par_err_cnt", 32'(err_rises - e0), 32'd1);
    check("par_err_width", 32'(err_cycles), 32'(err_rises));
    check("par_key_hold", 32'(bus.ps2_key), 32'h175);
    e0 = err_rises;
    send_byte(8'h1C, 1'b0, 3);
    check("glitch_frame_key", 32'(bus.ps2_key), 32'h61C);
    check("glitch_frame_err", 32'(err_rises - e0), 32'd0);

    // 4: short glitch while idle
    bus.ps2_clk_in = 1'b0;
    wait_cyc(4);
    bus.ps2_clk_in = 1'b1;
    wait_cyc(3 * HALF);
    check("idle_glitch_err", 32'(err_rises - e0), 32'd0);
    check("idle_glitch_key", 32'(bus.ps2_key), 32'h61C);

    // 5: stall after start + 3 data bits
    send_bits(mk_frame(8'h75, 1'b0), 4, -1);
    wait_cyc(TO - 50);
    check("tmo_early", 32'(err_rises - e0), 32'd0);
    wait_cyc(100);
    check("tmo_fire", 32'(err_rises - e0), 32'd1);
    send_byte(8'h75, 1'b0, -1);
    check("tmo_next_key", 32'(bus.ps2_key), 32'h275);
    check("tmo_next_err", 32'(err_rises - e0), 32'd1);

    // 6: Pause sequence, FA, then 29
    send_byte(8'hE1, 1'b0, -1);
    send_byte(8'h14, 1'b0, -1);
    send_byte(8'h77, 1'b0, -1);
    send_byte(8'hE1, 1'b0, -1);
    send_byte(8'hF0, 1'b0, -1);
    send_byte(8'h14, 1'b0, -1);
    send_byte(8'hF0, 1'b0, -1);
    send_byte(8'h77, 1'b0, -1);
    check("pause_hold", 32'(bus.ps2_key), 32'h275);
    send_byte(8'hFA, 1'b0, -1);
    check("fa_hold", 32'(bus.ps2_key), 32'h275);
    send_byte(8'h29, 1'b0, -1);
    check("key_29", 32'(bus.ps2_key), 32'h629);

    // Reset mid-frame, then a full frame decodes
    send_bits(mk_frame(8'h33, 1'b0), 5, -1);
    bus.ps2_clk_in = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    #1;
    check("midrst_key", 32'(bus.ps2_key), 32'h000);
    check("midrst_err", 32'(bus.frame_err), 32'h0);
    bus.ps2_clk_in = 1'b1;
    bus.ps2_dat_in = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(30);
    send_byte(8'h5A, 1'b0, -1);
    check("post_rst_key", 32'(bus.ps2_key), 32'h65A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Decodes a raw PS/2 keyboard stream (clock and data lines) into the 11-bit toggle-strobed `ps2_key` event word that the core's key-mapping logic consumes. It is the producer side of that interface. It sits between the keyboard pins and the `emu` input logic.

## Interface

**Parameters**
- `FILTER_LEN`, default 8: number of consecutive equal samples the PS/2 clock must show before a level change is accepted.
- `TIMEOUT`, default 96000: number of `clk_sys` cycles without a falling clock edge that aborts a partial frame. At 48 MHz this is 2 ms.

**Ports**
- `clk_sys`, in, 1: system clock (48 MHz).
- `reset`, in, 1: asynchronous, active-high reset.
- `ps2_clk_in`, in, 1: raw PS/2 clock, asynchronous to `clk_sys`.
- `ps2_dat_in`, in, 1: raw PS/2 data, asynchronous to `clk_sys`.
- `ps2_key`, out, 11: key event word.
  - [10] toggles once per event.
  - [9] is 1 for pressed, 0 for released.
  - [8] is the extended (E0) flag.
  - [7:0] is the scancode.
- `frame_err`, out, 1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation

**Input conditioning**
- Both inputs pass through 2-flop synchronizers. The flops reset to 1.
- The synchronized clock feeds a `FILTER_LEN` shift register.
- The filtered clock `fclk` goes to 0 only when the register is all zeros, and to 1 only when it is all ones. It resets to 1.
- `fclk_fall` is a one-cycle pulse on each 1→0 transition of `fclk`.
- Data is sampled from the synchronized data line in the same cycle `fclk_fall` is high.

**Frame FSM** (states IDLE, DATA, PARITY, STOP; all actions on `fclk_fall`)
- IDLE:
  - data = 0 (start bit) → DATA, bit count = 0.
  - data = 1 → stay in IDLE, no error.
- DATA: shift the bit in, LSB first. After the 8th bit → PARITY.
- PARITY: store the bit → STOP.
- STOP: the frame is valid if the stop bit = 1 and the 8 data bits plus the parity bit contain an odd number of ones.
  - Valid: pulse `byte_valid` with the byte.
  - Invalid: pulse `frame_err`.
  - Either way → IDLE.
- Timeout counter:
  - Clears on every `fclk_fall` and while in IDLE.
  - When it reaches `TIMEOUT` in any non-IDLE state: → IDLE, pulse `frame_err`, discard partial data.

**Prefix decoder** (acts on `byte_valid`)
- E0: set `ext`. No event.
- F0: set `brk`. No event.
- E1: load `skip` = 7. Each following valid byte decrements `skip` and is discarded. This drops the 8-byte Pause sequence entirely. `ext` and `brk` are cleared.
- 00, AA, EE, FA, FE, FF (device responses and overrun): discarded, `ext` and `brk` cleared, no event.
- Any other byte b: `ps2_key` <= {~ps2_key[10], ~brk, ext, b}, then `ext` and `brk` are cleared.

**Error and reset behaviour**
- `frame_err` does not clear `ext`, `brk` or `skip`.
- Reset values:
  - `ps2_key` = 11'h000
  - `frame_err` = 0
  - FSM in IDLE
  - `ext`, `brk`, `skip` = 0
  - filter register all ones
- Reset mid-frame discards the partial frame. The first complete frame after reset is decoded normally.

## Timing

- `fclk_fall` fires 2 (synchronizer) + `FILTER_LEN` cycles after a clean falling edge at the pin.
- `byte_valid` and `frame_err` go high the cycle after the `fclk_fall` that samples the stop bit.
- `ps2_key` updates the cycle after `byte_valid`, i.e. 2 cycles after the stop-bit `fclk_fall`.
- `ps2_key` holds its value between events. Consumers detect new events by a change in bit 10.
- At most one event per frame. The 11-bit frame at 10–16.7 kHz is far slower than the 2-cycle pipeline, so events never collide.
- A clock glitch shorter than `FILTER_LEN` cycles produces no `fclk_fall`.

## Structure

- Package `ps2_pkg` holds:
  - the state enum (IDLE/DATA/PARITY/STOP);
  - the prefix constants (E0, F0, E1);
  - the discard-code list;
  - the skip count for the Pause sequence (7).
- One sub-module, `ps2_line_filter`: synchronizers, glitch filter and `fclk_fall` edge detect.
- The FSM, timeout counter and prefix decoder live in `ps2_key_decoder`.

## Test plan

1. Frame 0x1D (parity 1, stop 1) from reset → `ps2_key` = 11'h61D, 2 cycles after the stop-bit `fclk_fall`. `frame_err` stays 0.
2. Following frames E0, F0, 75 → `ps2_key` = 11'h175 (toggle back to 0, release, extended). No change after E0 or F0 alone.
3. Frame 0x1C with parity bit inverted → `frame_err` pulses for 1 cycle, `ps2_key` unchanged. The next valid 0x1C → 11'h61C, with bit 10 flipped relative to its previous value.
4. A 4-cycle low glitch on `ps2_clk_in` while in IDLE (`FILTER_LEN` = 8) → no state change, no error. A glitch inside a frame does not shift in an extra bit.
5. Stop clocking after start plus 3 data bits, wait `TIMEOUT` + 1 cycles → one `frame_err` pulse, FSM back in IDLE. The next frame 0x75 → event with code 75.
6. Pause sequence E1 14 77 E1 F0 14 F0 77, then FA, then 0x29 → only one event: 11'h229 or 11'h629, depending on the toggle state. Asserting `reset` mid-frame → `ps2_key` = 0 immediately, and the next full frame decodes.
